// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: D-stage register-use hazard
// detection against E/M, a mult/div busy FSM, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_md,
    input  logic [4:0]  e_dst,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_dst,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        en_pc,
    output logic        en_d,
    output logic        flush_e,
    output logic        en_m,
    output logic        en_w,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        md_done_q, md_done_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic hz_rs, hz_rt, stall;

    // tuse == 3 marks an operand the D-stage instruction does not read.
    assign hz_rs = (d_rs != 5'd0) && (d_tuse_rs != 2'd3) &&
                   (((d_rs == e_dst) && (e_tnew > d_tuse_rs)) ||
                    ((d_rs == m_dst) && (m_tnew > d_tuse_rs)));
    assign hz_rt = (d_rt != 5'd0) && (d_tuse_rt != 2'd3) &&
                   (((d_rt == e_dst) && (e_tnew > d_tuse_rt)) ||
                    ((d_rt == m_dst) && (m_tnew > d_tuse_rt)));

    // A start in E counts as busy so a same-cycle mfhi/mflo in D is held.
    assign md_busy = ~reset & ((state_q == BUSY) | e_md_start);
    assign stall   = ~reset & (hz_rs | hz_rt | (d_md & md_busy));

    assign en_pc     = ~stall;
    assign en_d      = ~stall;
    assign flush_e   = stall;
    assign en_m      = 1'b1;
    assign en_w      = 1'b1;
    assign md_done   = md_done_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (e_md_start) begin
                    state_d = BUSY;
                    cnt_d   = e_md_div ? DIV_CNT : MULT_CNT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d   = IDLE;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard compares, mult/div busy timing,
// reset mid-operation, start-while-busy and stall counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_dst, m_dst;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_md, e_md_start, e_md_div;
    logic        en_pc, en_d, flush_e, en_m, en_w, md_busy, md_done;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md       (d_md),
        .e_dst      (e_dst),
        .e_tnew     (e_tnew),
        .m_dst      (m_dst),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .en_pc      (en_pc),
        .en_d       (en_d),
        .flush_e    (flush_e),
        .en_m       (en_m),
        .en_w       (en_w),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_inputs();
        d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_md = 0;
        e_dst = 0; e_tnew = 0; m_dst = 0; m_tnew = 0;
        e_md_start = 0; e_md_div = 0;
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clr_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int  busy_cycles;
        bit  done_seen;
        reset = 1'b1;
        clr_inputs();

        // Reset state, with hazard and start inputs active during reset
        repeat (2) @(negedge clk);
        e_dst = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        e_md_start = 1'b1; d_md = 1'b1;
        #1;
        check("rst_en_pc", en_pc, 1);
        check("rst_flush_e", flush_e, 0);
        check("rst_md_busy", md_busy, 0);
        @(negedge clk);
        clr_inputs();
        reset = 1'b0;
        #1;
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_md_done", md_done, 0);
        check("en_m", en_m, 1);
        check("en_w", en_w, 1);

        // 1) lw in E, dependent addu in D
        e_dst = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        #1;
        check("lw_en_pc", en_pc, 0);
        check("lw_en_d", en_d, 0);
        check("lw_flush_e", flush_e, 1);
        @(negedge clk);
        e_dst = 0; e_tnew = 0;
        #1;
        check("lw_after_en_pc", en_pc, 1);
        check("lw_after_flush", flush_e, 0);
        check("lw_stall_cnt", stall_cnt, 1);

        // 2) $0 never hazards; unused operand never hazards; M stage compare
        @(negedge clk);
        clr_inputs();
        e_dst = 0; e_tnew = 2'd2; d_rs = 0; d_tuse_rs = 2'd1;
        #1;
        check("zero_reg_en_pc", en_pc, 1);
        @(negedge clk);
        e_dst = 5'd5; d_rs = 5'd5; d_tuse_rs = 2'd3;
        #1;
        check("tuse3_flush", flush_e, 0);
        @(negedge clk);
        clr_inputs();
        m_dst = 5'd9; m_tnew = 2'd1; d_rt = 5'd9; d_tuse_rt = 2'd0;
        #1;
        check("m_rt_hazard", flush_e, 1);
        @(negedge clk);
        d_tuse_rt = 2'd1;
        #1;
        check("m_rt_equal_tnew", flush_e, 0);

        // 3) mult start followed by mfhi held in D
        do_reset();
        e_md_start = 1'b1; e_md_div = 1'b0; d_md = 1'b1;
        #1;
        check("mult_start_busy", md_busy, 1);
        check("mult_start_en_d", en_d, 0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e_md_start = 1'b0;
            #1;
            check("mult_busy", md_busy, 1);
            check("mult_en_d", en_d, 0);
            check("mult_done_early", md_done, 0);
        end
        @(negedge clk);
        #1;
        check("mult_done", md_done, 1);
        check("mult_idle", md_busy, 0);
        check("mult_en_d_release", en_d, 1);
        check("mult_stall_cnt", stall_cnt, 6);
        @(negedge clk);
        #1;
        check("mult_done_pulse", md_done, 0);

        // 4) div start, reset on the 4th BUSY cycle
        do_reset();
        e_md_start = 1'b1; e_md_div = 1'b1; d_md = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            e_md_start = 1'b0;
        end
        #1;
        check("div_busy4", md_busy, 1);
        check("div_stall_cnt4", stall_cnt, 4);
        reset = 1'b1;
        #1;
        check("div_rst_busy", md_busy, 0);
        check("div_rst_en_pc", en_pc, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("div_after_rst_busy", md_busy, 0);
        check("div_after_rst_done", md_done, 0);
        check("div_after_rst_cnt", stall_cnt, 0);
        @(negedge clk);
        #1;
        check("div_after_rst_done2", md_done, 0);
        check("div_after_rst_busy2", md_busy, 0);

        // 5) start pulsed again during a div's BUSY period
        do_reset();
        e_md_start = 1'b1; e_md_div = 1'b1;
        busy_cycles = 0;
        done_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            e_md_start = (k == 3);
            e_md_div   = 1'b0;
            #1;
            if (md_done) begin
                done_seen = 1'b1;
                break;
            end
            if (md_busy) busy_cycles++;
        end
        check("restart_done_seen", done_seen, 1);
        check("restart_busy_cycles", busy_cycles, 10);

        // 6) stall counter saturation
        do_reset();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        e_dst = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd0;
        @(negedge clk);
        #1;
        check("sat_reach", stall_cnt, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        #1;
        check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        check("sat_still_stall", flush_e, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
